gate_exerciser: RTL

Self-checking stimulus/response block for the two-input gate labs. It drives the A and B inputs of a gate under test through all four input combinations, waits a programmable settle time for each, samples the gate output X, and compares it against a 4-bit expected truth table. It sits on the tester side of the NAND-built gate circuits (AND, OR, NOR, XOR built from 7400 gates), whether the gate is simulated or a physical IC.

---
 rtl/gate_lab_pkg.sv | 17 +
 rtl/sync2.sv | 21 ++
 rtl/gate_exerciser.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gate_lab_pkg.sv
// rtl/gate_lab_pkg.sv - shared state enum and truth-table constants for the gate labs
package gate_lab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Truth tables indexed by {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser, resets to 0
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - drives a two-input gate through all four vectors and checks X
module gate_exerciser
  import gate_lab_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       x,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam int W  = SETTLE_CYCLES + 2;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [3:0]    exp_q;
  logic          x_s;
  logic          accept;
  logic          win_end;
  logic          mismatch;
  logic [3:0]    new_mask;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (x),
    .q     (x_s)
  );

  assign win_end  = (cnt == CNT_LAST);
  assign mismatch = x_s ^ exp_q[idx];
  assign new_mask = fail_mask | (4'(mismatch) << idx);

  // Vector is only driven while running; DONE and IDLE park the gate at 00
  assign a = (state_q == RUN) & idx[1];
  assign b = (state_q == RUN) & idx[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The edge leaving DONE may already accept the next start, so back-to-back
  // runs are spaced 4W+1 cycles apart.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (win_end && idx == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      cnt       <= '0;
      exp_q     <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
    end else if (accept) begin
      idx       <= 2'd0;
      cnt       <= '0;
      exp_q     <= expected;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (win_end) begin
            cnt       <= '0;
            fail_mask <= new_mask;
            if (idx == 2'd3) begin
              done <= 1'b1;
              busy <= 1'b0;
              pass <= (new_mask == 4'd0);
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
